// File: rtl/alu_issuer.sv
// alu_issuer: queues host ALU commands and issues them one at a time to an ALU.
// It then waits for the result, or times out, and returns each result to the host
// in command order.
//
// Only one command is ever outstanding at the ALU. When the command FIFO is empty
// and the issuer is idle, a command can go straight from the host port to the ALU.
// In that case o_alu_valid rises in the cycle right after the command is accepted.
//
// Ports
//   i_clk, i_rst_n                         clock, async active-low reset
//   i_cmd_valid/o_cmd_ready                host command handshake
//   i_cmd_inst/i_cmd_a/i_cmd_b             host command fields
//   o_alu_valid                            one-cycle issue strobe
//   o_alu_inst/o_alu_a/o_alu_b             issued command (held between issues)
//   i_alu_busy                             ALU cannot take an issue this cycle
//   i_alu_out_valid/i_alu_data             ALU result strobe and data
//   o_res_valid/o_res_inst/o_res_data/o_res_err   result to host
//   i_res_ready                            host accepts result
//   o_timeout_cnt                          saturating count of timed-out commands
module alu_issuer #(
    parameter int INST_W  = 4,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [INST_W-1:0] i_cmd_inst,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    output logic              o_alu_valid,
    input  logic              i_alu_busy,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_out_valid,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic              o_res_valid,
    output logic [INST_W-1:0] o_res_inst,
    output logic [DATA_W-1:0] o_res_data,
    output logic              o_res_err,
    input  logic              i_res_ready,
    output logic [7:0]        o_timeout_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    cmd_t              fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [WW-1:0]     wcnt_q;
    logic              alu_valid_q;
    cmd_t              alu_cmd_q;
    logic [INST_W-1:0] res_inst_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_err_q;
    logic [7:0]        tcnt_q;

    logic full, empty, push, issue, store, pop_fifo, wait_done, wait_expired;
    cmd_t cmd_in, head;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = i_cmd_valid && !full;
    assign cmd_in   = '{inst: i_cmd_inst, a: i_cmd_a, b: i_cmd_b};
    // When the FIFO is empty, the incoming command is the head. This bypass gives
    // single-cycle push-to-issue latency.
    assign head     = empty ? cmd_in : fifo_q[rd_ptr_q];
    assign issue    = (state_q == S_IDLE) && !i_alu_busy && (!empty || push);
    // A bypassed command never lands in storage.
    assign store    = push && !(empty && issue);
    assign pop_fifo = issue && !empty;
    assign count_d  = count_q + CW'(push) - CW'(issue);

    assign wait_done    = (state_q == S_WAIT) && i_alu_out_valid;
    assign wait_expired = (state_q == S_WAIT) && !i_alu_out_valid
                          && (wcnt_q == WW'(TIMEOUT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_WAIT;
            S_WAIT:  if (wait_done || wait_expired) state_d = S_RESP;
            S_RESP:  if (i_res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_cmd_ready   = !full;
        o_res_valid   = (state_q == S_RESP);
        o_alu_valid   = alu_valid_q;
        o_alu_inst    = alu_cmd_q.inst;
        o_alu_a       = alu_cmd_q.a;
        o_alu_b       = alu_cmd_q.b;
        o_res_inst    = res_inst_q;
        o_res_data    = res_data_q;
        o_res_err     = res_err_q;
        o_timeout_cnt = tcnt_q;
    end

    // ---------------- command FIFO ----------------
    // The storage needs no reset: the pointers and the count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (store) fifo_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (store)    wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_fifo) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // ---------------- issue, wait and result registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            wcnt_q      <= '0;
            res_inst_q  <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            alu_valid_q <= issue;
            if (issue) begin
                alu_cmd_q <= head;
                wcnt_q    <= '0;
            end else if (state_q == S_WAIT) begin
                wcnt_q <= wcnt_q + WW'(1);
            end

            if (wait_done) begin
                res_inst_q <= alu_cmd_q.inst;
                res_data_q <= i_alu_data;
                res_err_q  <= 1'b0;
            end else if (wait_expired) begin
                res_inst_q <= alu_cmd_q.inst;
                res_data_q <= '0;
                res_err_q  <= 1'b1;
                if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issuer.sv
// Testbench for alu_issuer. It runs directed scenarios with literal expectations.
// A queue-based reference model runs alongside and checks every cycle at the
// falling edge. The model tracks command order, one-outstanding issue, busy gating,
// result fields and the timeout count.
module tb_alu_issuer;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [3:0]  i_cmd_inst;
    logic [15:0] i_cmd_a, i_cmd_b;
    logic        o_alu_valid;
    logic        i_alu_busy;
    logic [3:0]  o_alu_inst;
    logic [15:0] o_alu_a, o_alu_b;
    logic        i_alu_out_valid;
    logic [15:0] i_alu_data;
    logic        o_res_valid;
    logic [3:0]  o_res_inst;
    logic [15:0] o_res_data;
    logic        o_res_err;
    logic        i_res_ready;
    logic [7:0]  o_timeout_cnt;

    alu_issuer #(.INST_W(4), .DATA_W(16), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_inst(i_cmd_inst), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
        .o_alu_valid(o_alu_valid), .i_alu_busy(i_alu_busy),
        .o_alu_inst(o_alu_inst), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_out_valid(i_alu_out_valid), .i_alu_data(i_alu_data),
        .o_res_valid(o_res_valid), .o_res_inst(o_res_inst), .o_res_data(o_res_data),
        .o_res_err(o_res_err), .i_res_ready(i_res_ready), .o_timeout_cnt(o_timeout_cnt)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- ALU responder ----------------
    logic        alu_silent = 1'b0;
    logic        spur_req   = 1'b0;
    logic        pend       = 1'b0;
    int          pwait      = 0;
    logic [15:0] pdata      = '0;

    always begin
        @(posedge i_clk);
        #1;
        i_alu_out_valid = 1'b0;
        if (!i_rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pwait == 0) begin
                    i_alu_out_valid = 1'b1;
                    i_alu_data      = pdata;
                    pend            = 1'b0;
                end else pwait--;
            end else if (spur_req) begin
                i_alu_out_valid = 1'b1;
                i_alu_data      = 16'h7FFF;
                spur_req        = 1'b0;
            end
            if (o_alu_valid && !alu_silent) begin
                pend  = 1'b1;
                pwait = 0;
                pdata = o_alu_a + o_alu_b;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct { logic [3:0] inst; logic [15:0] a; logic [15:0] b; } mcmd_t;
    typedef struct { logic [3:0] inst; logic [15:0] data; logic err; logic [7:0] tc; } mres_t;

    mcmd_t cmd_q[$];
    mres_t res_q[$];
    logic  prev_busy = 1'b1;
    int    tc_model  = 0;

    always @(negedge i_clk) begin : cmp
        mcmd_t c;
        mres_t r;
        logic [15:0] s;
        if (!i_rst_n) begin
            cmd_q.delete();
            res_q.delete();
            tc_model  = 0;
            prev_busy = 1'b1;
        end else begin
            if (o_alu_valid) begin
                chk("m_issue_while_busy", {31'd0, prev_busy}, 32'd0);
                chk("m_issue_outstanding", res_q.size(), 0);
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_issue_unexpected: got issue inst 0x%0h, expected no command", o_alu_inst);
                end else begin
                    c = cmd_q.pop_front();
                    chk("m_issue_inst", o_alu_inst, c.inst);
                    chk("m_issue_a", o_alu_a, c.a);
                    chk("m_issue_b", o_alu_b, c.b);
                    s = c.a + c.b;
                    r.inst = c.inst;
                    r.err  = alu_silent;
                    r.data = alu_silent ? 16'h0000 : s;
                    if (alu_silent && tc_model < 255) tc_model++;
                    r.tc = 8'(tc_model);
                    res_q.push_back(r);
                end
            end
            chk("m_cmd_ready", {31'd0, o_cmd_ready}, {31'd0, cmd_q.size() < DEPTH});
            if (o_res_valid) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m_res_unexpected: got result inst 0x%0h, expected none", o_res_inst);
                end else begin
                    r = res_q[0];
                    chk("m_res_inst", o_res_inst, r.inst);
                    chk("m_res_data", o_res_data, r.data);
                    chk("m_res_err", {31'd0, o_res_err}, {31'd0, r.err});
                    chk("m_timeout_cnt", o_timeout_cnt, r.tc);
                    if (i_res_ready) void'(res_q.pop_front());
                end
            end
            if (i_cmd_valid && cmd_q.size() < DEPTH) begin
                c.inst = i_cmd_inst; c.a = i_cmd_a; c.b = i_cmd_b;
                cmd_q.push_back(c);
            end
            prev_busy = i_alu_busy;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic push(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
        i_cmd_valid = 1'b1; i_cmd_inst = inst; i_cmd_a = a; i_cmd_b = b;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!o_res_valid && n < 200) begin
            tick();
            n++;
        end
        if (!o_res_valid) begin
            checks++; errors++;
            $display("FAIL res_wait: got no o_res_valid in %0d cycles, expected a result", n);
        end
    endtask

    task automatic take_result(input string name, input logic [3:0] inst,
                               input logic [15:0] data, input logic err);
        int n;
        wait_res(n);
        chk({name, "_inst"}, o_res_inst, inst);
        chk({name, "_data"}, o_res_data, data);
        chk({name, "_err"}, {31'd0, o_res_err}, {31'd0, err});
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_inst = '0; i_cmd_a = '0; i_cmd_b = '0;
        i_alu_busy = 1'b0; i_alu_data = '0; i_alu_out_valid = 1'b0; i_res_ready = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_alu_valid", {31'd0, o_alu_valid}, 32'd0);
        chk("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("rst_alu_fields", {o_alu_inst, o_alu_a, o_alu_b}, '0);
        chk("rst_res_fields", {o_res_err, o_res_inst, o_res_data}, '0);
        chk("rst_timeout_cnt", o_timeout_cnt, 32'd0);

        // single command: issue one cycle after push, ALU answers one cycle later
        push(4'd0, 16'h0400, 16'h0800);
        chk("t1_issue_lat", {31'd0, o_alu_valid}, 32'd1);
        chk("t1_issue_a", o_alu_a, 32'h0400);
        wait_res(n);
        chk("t1_res_lat", n, 32'd2);
        take_result("t1", 4'd0, 16'h0C00, 1'b0);

        // busy holds everything in the FIFO until it fills
        i_alu_busy = 1'b1;
        push(4'd1, 16'h0100, 16'h0200);
        push(4'd2, 16'h0400, 16'h0400);
        push(4'd3, 16'h1000, 16'h0001);
        push(4'd4, 16'hF000, 16'h2000);
        chk("t2_full_ready", {31'd0, o_cmd_ready}, 32'd0);
        push(4'd15, 16'hDEAD, 16'hBEEF);   // offered while full, must be dropped
        chk("t2_no_issue", {31'd0, o_alu_valid}, 32'd0);
        i_alu_busy = 1'b0;
        take_result("t2_r1", 4'd1, 16'h0300, 1'b0);
        take_result("t2_r2", 4'd2, 16'h0800, 1'b0);
        take_result("t2_r3", 4'd3, 16'h1001, 1'b0);
        take_result("t2_r4", 4'd4, 16'h1000, 1'b0);

        // silent ALU: timeout after 64 cycles
        alu_silent = 1'b1;
        push(4'd5, 16'h0111, 16'h0222);
        chk("t3_issue", {31'd0, o_alu_valid}, 32'd1);
        wait_res(n);
        chk("t3_timeout_lat", n, 32'd64);
        chk("t3_timeout_cnt", o_timeout_cnt, 32'd1);
        take_result("t3", 4'd5, 16'h0000, 1'b1);
        alu_silent = 1'b0;
        tick();

        // host stalls for 10 cycles in RESP; next issue follows release
        push(4'd6, 16'h0010, 16'h0020);
        push(4'd7, 16'h0003, 16'h0004);
        wait_res(n);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", {31'd0, o_res_valid}, 32'd1);
            chk("t4_hold_data", o_res_data, 32'h0030);
            chk("t4_hold_no_issue", {31'd0, o_alu_valid}, 32'd0);
            if (i == 3) spur_req = 1'b1;
            tick();
        end
        chk("t4_hold_inst", o_res_inst, 32'd6);
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        chk("t4_res_drop", {31'd0, o_res_valid}, 32'd0);
        chk("t4_idle_cycle", {31'd0, o_alu_valid}, 32'd0);
        tick();
        chk("t4_next_issue", {31'd0, o_alu_valid}, 32'd1);
        chk("t4_next_inst", o_alu_inst, 32'd7);
        take_result("t4_r7", 4'd7, 16'h0007, 1'b0);

        // push and pop together at occupancy 3
        i_alu_busy = 1'b1;
        push(4'd8,  16'h0200, 16'h0300);
        push(4'd9,  16'h7FFF, 16'h0001);
        push(4'd10, 16'h0000, 16'h0000);
        i_alu_busy = 1'b0;
        push(4'd11, 16'h1234, 16'h4321);
        chk("t5_ready_kept", {31'd0, o_cmd_ready}, 32'd1);
        chk("t5_pop_issue", {31'd0, o_alu_valid}, 32'd1);
        chk("t5_pop_inst", o_alu_inst, 32'd8);
        take_result("t5_r8",  4'd8,  16'h0500, 1'b0);
        take_result("t5_r9",  4'd9,  16'h8000, 1'b0);
        take_result("t5_r10", 4'd10, 16'h0000, 1'b0);
        take_result("t5_r11", 4'd11, 16'h5555, 1'b0);

        // reset during WAIT with two commands queued
        alu_silent = 1'b1;
        push(4'd12, 16'h0001, 16'h0002);
        push(4'd13, 16'h0003, 16'h0004);
        push(4'd14, 16'h0005, 16'h0006);
        repeat (4) tick();
        i_rst_n = 1'b0;
        tick();
        chk("t6_rst_alu_valid", {31'd0, o_alu_valid}, 32'd0);
        chk("t6_rst_res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("t6_rst_alu_fields", {o_alu_inst, o_alu_a, o_alu_b}, '0);
        chk("t6_rst_res_fields", {o_res_err, o_res_inst, o_res_data}, '0);
        chk("t6_rst_timeout_cnt", o_timeout_cnt, 32'd0);
        alu_silent = 1'b0;
        i_rst_n = 1'b1;
        tick();
        chk("t6_ready_after", {31'd0, o_cmd_ready}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (o_res_valid || o_alu_valid) cnt++;
            tick();
        end
        chk("t6_no_stale_activity", cnt, 32'd0);
        push(4'd15, 16'h0001, 16'h0001);
        take_result("t6_r15", 4'd15, 16'h0002, 1'b0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
